uart_tx_buffered: RTL and testbench

Buffered, runtime-configurable UART transmitter. Words enter through a valid/ready stream port into an internal FIFO. They are serialised LSB-first on TXD with configurable baud divisor, parity mode and stop-bit count. The block sits between a host/bus-side producer and the serial pin and replaces the single-word, fixed-configuration transmitter in new designs.

---
 rtl/uart_tx_buffered.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
//
// Buffered UART transmitter with runtime configuration. Words are accepted
// through a valid/ready port into a FIFO and sent LSB-first on TXD. Each frame
// carries its own baud divisor, parity mode and stop-bit count, captured when
// the word leaves the FIFO.
//
// Ports:
//   clk          clock, rising edge
//   arstn        asynchronous active-low reset
//   s_valid      producer offers s_data
//   s_ready      FIFO not full (depends only on registered state)
//   s_data       word to send
//   baud_div     bit period = baud_div+1 clk cycles
//   parity_mode  00 none, 01 odd, 10 even, 11 mark
//   two_stop     0 = one stop bit, 1 = two stop bits
//   TXD          serial output, registered, idle high
//   busy         high while a frame is on the line
//   tx_done      one-cycle pulse during the last cycle of each frame
//   fifo_level   number of words stored in the FIFO
// -----------------------------------------------------------------------------
module uart_tx_buffered #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          arstn,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_WIDTH-1:0]         s_data,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    output logic                          TXD,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [0:FIFO_DEPTH-1];
    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [LW-1:0]         level_reg;
    logic                  push;
    logic                  pop;
    logic                  empty;
    logic [DATA_WIDTH-1:0] head;

    assign empty   = (level_reg == '0);
    assign s_ready = (level_reg != LW'(FIFO_DEPTH));
    assign push    = s_valid && s_ready;
    // Head is read directly so the word can be latched on the same edge
    // that pops it; this keeps the push-to-start latency at one cycle.
    assign head    = mem[rd_ptr_reg];

    // Storage has no reset: discarding the contents only needs the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t                state_reg;
    logic [DIV_WIDTH-1:0]  div_cnt_reg;
    logic [BW-1:0]         bit_cnt_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DIV_WIDTH-1:0]  sh_div_reg;
    logic [1:0]            sh_mode_reg;
    logic                  sh_two_stop_reg;
    logic                  sh_par_reg;
    logic                  txd_reg;
    logic                  busy_reg;
    logic                  done_reg;

    logic bit_end;
    logic final_stop;
    logic frame_end;
    logic div_zero;

    assign bit_end    = (div_cnt_reg == sh_div_reg);
    assign final_stop = (state_reg == STOP2) || ((state_reg == STOP1) && !sh_two_stop_reg);
    assign frame_end  = final_stop && bit_end;
    assign pop        = !empty && ((state_reg == IDLE) || frame_end);
    // With a one-cycle bit, entering the final stop bit is already the last
    // cycle of the frame, so tx_done has to be raised on that transition.
    assign div_zero   = (sh_div_reg == '0);

    function automatic logic parity_bit(input logic [1:0] mode, input logic [DATA_WIDTH-1:0] d);
        case (mode)
            2'b01:   parity_bit = ~^d;
            2'b10:   parity_bit = ^d;
            2'b11:   parity_bit = 1'b1;
            default: parity_bit = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_reg       <= IDLE;
            div_cnt_reg     <= '0;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            sh_div_reg      <= '0;
            sh_mode_reg     <= 2'b00;
            sh_two_stop_reg <= 1'b0;
            sh_par_reg      <= 1'b0;
            txd_reg         <= 1'b1;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (pop) begin
                // Start of a frame, either from idle or straight after the
                // previous frame's final stop bit.
                shift_reg       <= head;
                sh_div_reg      <= baud_div;
                sh_mode_reg     <= parity_mode;
                sh_two_stop_reg <= two_stop;
                sh_par_reg      <= parity_bit(parity_mode, head);
                div_cnt_reg     <= '0;
                bit_cnt_reg     <= '0;
                txd_reg         <= 1'b0;
                busy_reg        <= 1'b1;
                state_reg       <= START;
            end else if (state_reg == IDLE) begin
                txd_reg  <= 1'b1;
                busy_reg <= 1'b0;
            end else if (frame_end) begin
                div_cnt_reg <= '0;
                txd_reg     <= 1'b1;
                busy_reg    <= 1'b0;
                state_reg   <= IDLE;
            end else if (!bit_end) begin
                div_cnt_reg <= div_cnt_reg + 1'b1;
                if (final_stop && ((div_cnt_reg + 1'b1) == sh_div_reg)) begin
                    done_reg <= 1'b1;
                end
            end else begin
                div_cnt_reg <= '0;
                case (state_reg)
                    START: begin
                        txd_reg   <= shift_reg[0];
                        state_reg <= DATA;
                    end
                    DATA: begin
                        if (bit_cnt_reg == BW'(DATA_WIDTH - 1)) begin
                            bit_cnt_reg <= '0;
                            if (sh_mode_reg != 2'b00) begin
                                txd_reg   <= sh_par_reg;
                                state_reg <= PARITY;
                            end else begin
                                txd_reg   <= 1'b1;
                                state_reg <= STOP1;
                                done_reg  <= !sh_two_stop_reg && div_zero;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            shift_reg   <= shift_reg >> 1;
                            txd_reg     <= shift_reg[1];
                        end
                    end
                    PARITY: begin
                        txd_reg   <= 1'b1;
                        state_reg <= STOP1;
                        done_reg  <= !sh_two_stop_reg && div_zero;
                    end
                    STOP1: begin
                        // Only reached with two stop bits; the single-stop
                        // case ends through frame_end above.
                        txd_reg   <= 1'b1;
                        state_reg <= STOP2;
                        done_reg  <= div_zero;
                    end
                    default: begin
                        txd_reg   <= 1'b1;
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign TXD        = txd_reg;
    assign busy       = busy_reg;
    assign tx_done    = done_reg;
    assign fifo_level = level_reg;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buffered
//
// Directed bench for uart_tx_buffered. A table of single-frame vectors with
// hand-computed line sequences is applied in a loop; hand-written sequences
// cover 7-bit frames, FIFO fill, mid-frame config changes, simultaneous
// push/pop and asynchronous reset mid-frame. The line is recorded each cycle
// into capture arrays and decoded afterwards.
// -----------------------------------------------------------------------------
module tb_uart_tx_buffered;

    logic        clk = 1'b0;
    logic        arstn;

    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic        two_stop;
    logic        txd;
    logic        busy;
    logic        tx_done;
    logic [4:0]  fifo_level;

    logic        s_valid7;
    logic        s_ready7;
    logic [6:0]  s_data7;
    logic [15:0] baud_div7;
    logic [1:0]  parity_mode7;
    logic        two_stop7;
    logic        txd7;
    logic        busy7;
    logic        tx_done7;
    logic [4:0]  fifo_level7;

    always #5 clk = ~clk;

    uart_tx_buffered #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
        .clk(clk), .arstn(arstn), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .baud_div(baud_div), .parity_mode(parity_mode),
        .two_stop(two_stop), .TXD(txd), .busy(busy), .tx_done(tx_done),
        .fifo_level(fifo_level)
    );

    uart_tx_buffered #(.DATA_WIDTH(7), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut7 (
        .clk(clk), .arstn(arstn), .s_valid(s_valid7), .s_ready(s_ready7),
        .s_data(s_data7), .baud_div(baud_div7), .parity_mode(parity_mode7),
        .two_stop(two_stop7), .TXD(txd7), .busy(busy7), .tx_done(tx_done7),
        .fifo_level(fifo_level7)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Line capture (sampled on the falling edge, mid-cycle)
    // ------------------------------------------------------------------
    localparam int CAPN = 17100;
    logic cap_txd  [CAPN];
    logic cap_busy [CAPN];
    logic cap_done [CAPN];
    int   cap_n;
    bit   cap_en = 1'b0;

    always @(negedge clk) begin
        if (!cap_en) begin
            cap_n <= 0;
        end else if (cap_n < CAPN) begin
            cap_txd[cap_n]  <= txd;
            cap_busy[cap_n] <= busy;
            cap_done[cap_n] <= tx_done;
            cap_n           <= cap_n + 1;
        end
    end

    // Checks one frame starting at capture index 'at': every cycle of each bit
    // against seq, busy high throughout, tx_done exactly on the last cycle.
    task automatic chk_frame(input string name, input int at, input logic [0:11] seq,
                             input int nbits, input int div);
        int   f;
        int   pos;
        int   cnt;
        int   idx;
        logic act;
        logic bz;
        f   = nbits * (div + 1);
        pos = -1;
        cnt = 0;
        bz  = 1'b1;
        for (int b = 0; b < nbits; b++) begin
            act = seq[b];
            for (int c = 0; c <= div; c++) begin
                idx = at + b * (div + 1) + c;
                if (cap_txd[idx] !== seq[b]) act = cap_txd[idx];
                if (cap_busy[idx] !== 1'b1) bz = cap_busy[idx];
            end
            chk($sformatf("%s_bit%0d", name, b), 32'(act), 32'(seq[b]));
        end
        chk($sformatf("%s_busy", name), 32'(bz), 32'd1);
        for (int t = 0; t < f; t++) begin
            if (cap_done[at + t] === 1'b1) begin
                cnt++;
                if (pos < 0) pos = t;
            end
        end
        chk($sformatf("%s_done_pos", name), pos, f - 1);
        chk($sformatf("%s_done_cnt", name), cnt, 1);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        logic [1:0]  pmode;
        logic        two;
        logic [0:11] seq;    // line bits in transmit order, index 0 = start
        int          nbits;
    } vec_t;

    vec_t vt[7];

    initial begin
        int          f;
        int          k;
        int          nxt;
        logic        rdy;
        logic        bad;
        logic [0:10] seq7;
        logic [0:11] seq_a;
        logic [0:11] seq_b;
        logic [7:0]  kb;

        vt[0] = '{8'hA5, 16'd3, 2'b10, 1'b0, 12'b0_10100101_0_1_0, 11};
        vt[1] = '{8'h3C, 16'd1, 2'b00, 1'b1, 12'b0_00111100_1_1_0, 11};
        vt[2] = '{8'h01, 16'd0, 2'b01, 1'b0, 12'b0_10000000_0_1_0, 11};
        vt[3] = '{8'h00, 16'd2, 2'b11, 1'b1, 12'b0_00000000_1_1_1, 12};
        vt[4] = '{8'hFF, 16'd0, 2'b10, 1'b0, 12'b0_11111111_0_1_0, 11};
        vt[5] = '{8'h80, 16'd1, 2'b01, 1'b0, 12'b0_00000001_0_1_0, 11};
        vt[6] = '{8'h5A, 16'd2, 2'b00, 1'b0, 12'b0_01011010_1_00, 10};

        arstn        = 1'b0;
        s_valid      = 1'b0;
        s_data       = '0;
        baud_div     = '0;
        parity_mode  = 2'b00;
        two_stop     = 1'b0;
        s_valid7     = 1'b0;
        s_data7      = '0;
        baud_div7    = '0;
        parity_mode7 = 2'b00;
        two_stop7    = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_done", 32'(tx_done), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_txd7", 32'(txd7), 32'd1);
        arstn = 1'b1;
        tick();
        tick();

        // ---------------- table of single frames ----------------
        for (int v = 0; v < 7; v++) begin
            s_data      = vt[v].data;
            baud_div    = vt[v].div;
            parity_mode = vt[v].pmode;
            two_stop    = vt[v].two;
            s_valid     = 1'b1;
            cap_en      = 1'b1;
            tick();
            chk($sformatf("v%0d_level_after_push", v), 32'(fifo_level), 32'd1);
            chk($sformatf("v%0d_txd_before_pop", v), 32'(txd), 32'd1);
            s_valid = 1'b0;
            tick();
            chk($sformatf("v%0d_txd_fall", v), 32'(txd), 32'd0);
            chk($sformatf("v%0d_level_after_pop", v), 32'(fifo_level), 32'd0);
            f = vt[v].nbits * (int'(vt[v].div) + 1);
            repeat (f + 2) tick();
            cap_en = 1'b0;
            tick();
            chk_frame($sformatf("v%0d", v), 2, vt[v].seq, vt[v].nbits, int'(vt[v].div));
            chk($sformatf("v%0d_idle_txd", v), 32'(cap_txd[2 + f]), 32'd1);
            chk($sformatf("v%0d_idle_busy", v), 32'(cap_busy[2 + f]), 32'd0);
        end

        // ---------------- 7-bit frame, odd parity, two stops ----------------
        seq7         = 11'b0_1111111_0_1_1;
        s_data7      = 7'h7F;
        baud_div7    = 16'd0;
        parity_mode7 = 2'b01;
        two_stop7    = 1'b1;
        s_valid7     = 1'b1;
        tick();
        s_valid7 = 1'b0;
        chk("w7_level_push", 32'(fifo_level7), 32'd1);
        tick();
        for (int t = 0; t < 11; t++) begin
            chk($sformatf("w7_bit%0d", t), 32'(txd7), 32'(seq7[t]));
            chk($sformatf("w7_done%0d", t), 32'(tx_done7), (t == 10) ? 32'd1 : 32'd0);
            tick();
        end
        chk("w7_busy_end", 32'(busy7), 32'd0);
        chk("w7_txd_idle", 32'(txd7), 32'd1);

        // ---------------- config change mid-frame ----------------
        seq_a       = 12'b0_01101001_1_00;   // 0x96, no parity, one stop
        seq_b       = 12'b0_11110000_0_1_1;  // 0x0F, even parity, two stops
        baud_div    = 16'd1;
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        cap_en      = 1'b1;
        s_data      = 8'h96;
        s_valid     = 1'b1;
        tick();
        s_data = 8'h0F;
        tick();
        s_valid = 1'b0;
        tick();
        tick();
        tick();
        parity_mode = 2'b10;
        two_stop    = 1'b1;
        repeat (60) tick();
        cap_en = 1'b0;
        tick();
        chk_frame("cfg_f1", 2, seq_a, 10, 1);
        chk_frame("cfg_f2", 22, seq_b, 12, 1);
        chk("cfg_idle", 32'(cap_txd[46]), 32'd1);

        // ---------------- simultaneous push and pop ----------------
        baud_div    = 16'd0;
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        s_valid     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = 8'h10 + 8'(i);
            tick();
        end
        s_valid = 1'b0;
        chk("sim_level_3", 32'(fifo_level), 32'd3);
        k = 0;
        while (tx_done !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        chk("sim_wait_done", 32'(tx_done), 32'd1);
        chk("sim_level_at_done", 32'(fifo_level), 32'd3);
        s_data  = 8'h14;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("sim_level_kept", 32'(fifo_level), 32'd3);
        chk("sim_next_start", 32'(txd), 32'd0);
        chk("sim_busy", 32'(busy), 32'd1);
        k = 0;
        while (busy !== 1'b0 && k < 200) begin
            tick();
            k++;
        end
        chk("sim_drained", 32'(busy), 32'd0);
        chk("sim_level_0", 32'(fifo_level), 32'd0);

        // ---------------- FIFO fill ----------------
        baud_div = 16'd99;
        cap_en   = 1'b1;
        nxt      = 0;
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(nxt);
            rdy     = s_ready;
            tick();
            if (rdy) begin
                nxt++;
                if (nxt == 17) begin
                    chk("fill_s_ready_fall", 32'(s_ready), 32'd0);
                    chk("fill_level_16", 32'(fifo_level), 32'd16);
                end
            end
        end
        s_valid = 1'b0;
        chk("fill_accepted", nxt, 17);
        chk("fill_still_full", 32'(s_ready), 32'd0);
        repeat (16990) tick();
        cap_en = 1'b0;
        tick();
        for (int fr = 0; fr < 17; fr++) begin
            kb    = 8'(fr);
            seq_a = '0;
            for (int i = 0; i < 8; i++) seq_a[1 + i] = kb[i];
            seq_a[9] = 1'b1;
            chk_frame($sformatf("fill_f%0d", fr), 2 + 1000 * fr, seq_a, 10, 99);
        end
        chk("fill_idle_txd", 32'(cap_txd[17002]), 32'd1);
        chk("fill_idle_busy", 32'(cap_busy[17002]), 32'd0);

        // ---------------- reset mid-frame ----------------
        baud_div = 16'd9;
        s_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_data = 8'hC0 + 8'(i);
            tick();
        end
        s_valid = 1'b0;
        chk("rmf_level_5", 32'(fifo_level), 32'd5);
        repeat (12) tick();
        chk("rmf_busy_before", 32'(busy), 32'd1);
        #1;
        arstn = 1'b0;
        #1;
        chk("rmf_txd", 32'(txd), 32'd1);
        chk("rmf_level", 32'(fifo_level), 32'd0);
        chk("rmf_s_ready", 32'(s_ready), 32'd1);
        chk("rmf_busy", 32'(busy), 32'd0);
        tick();
        arstn = 1'b0;
        tick();
        arstn = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (txd !== 1'b1 || busy !== 1'b0 || fifo_level !== 5'd0) bad = 1'b1;
        end
        chk("rmf_stays_idle", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
